// File: rtl/wm8731_pkg.sv
// Shared constants for the WM8731 power-up sequencer: register addresses, word layout,
// init table size and FSM state encoding.
package wm8731_pkg;

  localparam int WORD_W   = 16;
  localparam int IDX_W    = 4;
  localparam int NUM_REGS = 11;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } init_word_t;

  localparam logic [6:0] REG_LLINE  = 7'd0;
  localparam logic [6:0] REG_RLINE  = 7'd1;
  localparam logic [6:0] REG_LHP    = 7'd2;
  localparam logic [6:0] REG_RHP    = 7'd3;
  localparam logic [6:0] REG_APATH  = 7'd4;
  localparam logic [6:0] REG_DPATH  = 7'd5;
  localparam logic [6:0] REG_PWR    = 7'd6;
  localparam logic [6:0] REG_IFACE  = 7'd7;
  localparam logic [6:0] REG_SRATE  = 7'd8;
  localparam logic [6:0] REG_ACTIVE = 7'd9;
  localparam logic [6:0] REG_RESET  = 7'd15;

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  function automatic logic [WORD_W-1:0] mk_word(input logic [6:0] addr, input logic [8:0] data);
    init_word_t w;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/wm8731_init_rom.sv
// Combinational init table: entry index -> {addr, data} word; zero past the last entry.
module wm8731_init_rom
  import wm8731_pkg::*;
(
  input  logic [IDX_W-1:0]  i_idx,
  output logic [WORD_W-1:0] o_word
);

  // Reset first, then power-up before the datapath registers, activate last.
  always_comb begin
    o_word = '0;
    case (i_idx)
      4'd0:    o_word = mk_word(REG_RESET,  9'h000);
      4'd1:    o_word = mk_word(REG_PWR,    9'h010);
      4'd2:    o_word = mk_word(REG_LLINE,  9'h017);
      4'd3:    o_word = mk_word(REG_RLINE,  9'h017);
      4'd4:    o_word = mk_word(REG_LHP,    9'h079);
      4'd5:    o_word = mk_word(REG_RHP,    9'h079);
      4'd6:    o_word = mk_word(REG_APATH,  9'h012);
      4'd7:    o_word = mk_word(REG_DPATH,  9'h000);
      4'd8:    o_word = mk_word(REG_IFACE,  9'h04A);
      4'd9:    o_word = mk_word(REG_SRATE,  9'h000);
      4'd10:   o_word = mk_word(REG_ACTIVE, 9'h001);
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/wm8731_init_seq.sv
// WM8731 power-up sequencer: waits PWRUP_CYC, then writes the init table through the I2C
// write master one word at a time, retrying NACKed words up to MAX_RETRY times.
module wm8731_init_seq
  import wm8731_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 50000,
  parameter int unsigned GAP_CYC   = 100,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Restart_i,
  output logic              Wr_Req_o,
  output logic [WORD_W-1:0] Wr_Word_o,
  input  logic              Wr_Ack_i,
  input  logic              Wr_Done_i,
  input  logic              Wr_Nack_i,
  output logic              Init_Done_o,
  output logic              Init_Err_o,
  output logic [IDX_W-1:0]  Reg_Idx_o
);

  localparam int PW_W = $clog2(PWRUP_CYC + 1);
  localparam int GP_W = $clog2(GAP_CYC + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 1);

  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PWRUP_CYC - 1);
  localparam logic [GP_W-1:0]  GP_LAST  = GP_W'(GAP_CYC - 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  logic [2:0]        r_state;
  logic [PW_W-1:0]   r_pw_cnt;
  logic [GP_W-1:0]   r_gap_cnt;
  logic [RT_W-1:0]   r_retry;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_word;
  logic              r_req;
  logic              r_done;
  logic              r_err;
  logic              r_is_retry;
  logic              r_early_done;
  logic              r_early_nack;

  logic [WORD_W-1:0] w_rom_word;
  logic              w_done_evt;
  logic              w_nack_evt;

  wm8731_init_rom u_rom (
    .i_idx  (r_idx),
    .o_word (w_rom_word)
  );

  // A done that arrived together with the ack is held over and consumed in WAIT.
  assign w_done_evt = r_early_done | Wr_Done_i;
  assign w_nack_evt = r_early_done ? r_early_nack : Wr_Nack_i;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ST_PWRUP;
      r_pw_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_retry      <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_req        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_is_retry   <= 1'b0;
      r_early_done <= 1'b0;
      r_early_nack <= 1'b0;
    end else begin
      case (r_state)
        ST_PWRUP: begin
          if (r_pw_cnt == PW_LAST) begin
            r_pw_cnt <= '0;
            r_state  <= ST_LOAD;
          end else begin
            r_pw_cnt <= r_pw_cnt + PW_W'(1);
          end
        end
        ST_LOAD: begin
          r_word  <= w_rom_word;
          r_retry <= '0;
          r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (r_req && Wr_Ack_i) begin
            r_req        <= 1'b0;
            r_early_done <= Wr_Done_i;
            r_early_nack <= Wr_Nack_i;
            r_state      <= ST_WAIT;
          end else begin
            r_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_done_evt) begin
            r_early_done <= 1'b0;
            r_early_nack <= 1'b0;
            r_gap_cnt    <= '0;
            if (!w_nack_evt) begin
              if (r_idx == IDX_LAST) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_idx      <= r_idx + IDX_W'(1);
                r_is_retry <= 1'b0;
                r_state    <= ST_GAP;
              end
            end else if (r_retry < RT_MAX) begin
              r_retry    <= r_retry + RT_W'(1);
              r_is_retry <= 1'b1;
              r_state    <= ST_GAP;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_ERROR;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GP_LAST) begin
            r_state <= r_is_retry ? ST_REQ : ST_LOAD;
          end else begin
            r_gap_cnt <= r_gap_cnt + GP_W'(1);
          end
        end
        ST_DONE, ST_ERROR: begin
          if (Restart_i) begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_idx    <= '0;
            r_retry  <= '0;
            r_pw_cnt <= '0;
            r_state  <= ST_PWRUP;
          end
        end
        default: r_state <= ST_PWRUP;
      endcase
    end
  end

  assign Wr_Req_o    = r_req;
  assign Wr_Word_o   = r_word;
  assign Init_Done_o = r_done;
  assign Init_Err_o  = r_err;
  assign Reg_Idx_o   = r_idx;

endmodule
